audio_ram_ring_ctrl: RTL and testbench
======================================

# audio_ram_ring_ctrl

Ring-buffer controller and arbiter that shares one single-port 16-bit × 1024 on-chip RAM between a capture-side writer (ADC samples from the WM8731 I2S receiver) and a playback-side reader (DAC path). It grants at most one RAM access per cycle with round-robin priority and maintains write/read pointers and the fill level. It also realigns read data to the RAM's registered-output latency. It sits between the I2S sample logic and the single-port RAM instance.

## Interface

Parameters:
- ADDR_WIDTH, 10, RAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 16, sample width.
- RD_LATENCY, 2, RAM read latency in clocks from address capture to rd_data valid (1 = no output reg, 2 = output reg).

Ports:
- clk  in  1  clock.
- tb_rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous flush of pointers, level and sticky flags.
- wr_req  in  1  writer request; hold high with wr_data stable until wr_ack.
- wr_data  in  DATA_WIDTH  sample to store.
- wr_ack  out  1  one-cycle pulse; write issued to RAM this cycle.
- rd_req  in  1  reader request; hold high until rd_ack.
- rd_ack  out  1  one-cycle pulse; read issued to RAM this cycle.
- rd_valid  out  1  one-cycle pulse; rd_data_out holds the requested sample.
- rd_data_out  out  DATA_WIDTH  read sample, held until the next rd_valid.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_data  out  DATA_WIDTH  RAM write data.
- ram_rd_data  in  DATA_WIDTH  RAM read data.
- level  out  ADDR_WIDTH+1  stored sample count, 0..2**ADDR_WIDTH.
- full  out  1  level == 2**ADDR_WIDTH.
- empty  out  1  level == 0.
- overflow  out  1  sticky: wr_req seen while full.
- underflow  out  1  sticky: rd_req seen while empty.

## Operation

- Eligibility per cycle:
  - Writer: wr_req & ~wr_ack & ~full.
  - Reader: rd_req & ~rd_ack & ~empty.
  - A request is ignored in its own ack cycle, which prevents double grants.
- Arbiter state last_grant ∈ {WR, RD}, reset value WR.
  - Only one eligible requester: it wins.
  - Both eligible: the requester not named in last_grant wins.
  - last_grant updates on every grant.
- Write grant, all registered at the clock edge:
  - ram_wr_en=1, ram_addr=wptr, ram_wr_data=wr_data, wr_ack=1.
  - wptr increments mod 2**ADDR_WIDTH; level +1.
- Read grant, registered:
  - ram_wr_en=0, ram_addr=rptr, rd_ack=1.
  - rptr increments mod 2**ADDR_WIDTH; level −1.
  - A tag is pushed into a RD_LATENCY+1 deep valid shift register.
- When the tag exits the shift register: rd_data_out ← ram_rd_data, rd_valid=1.
- No grant in a cycle: ram_wr_en=0, acks 0; ram_addr and ram_wr_data hold their last values.
- level changes by at most ±1 per cycle, because only one access is granted per cycle.
- full and empty are registered and decoded from the next level value, so they are consistent with level in the same cycle.
- A full writer or empty reader stalls: no ack is issued and the requester keeps waiting. overflow or underflow is set and stays set until clr or reset.
- clr:
  - Takes priority over grants: wptr=rptr=0, level=0, empty=1, full=0, overflow=underflow=0, last_grant=WR, no ack that cycle.
  - In-flight read tags still complete; rd_valid still fires for them.
- Reset values of all outputs:
  - wr_ack=rd_ack=rd_valid=0, rd_data_out=0, ram_addr=0, ram_wr_en=0, ram_wr_data=0.
  - level=0, full=0, empty=1, overflow=0, underflow=0.
  - Pointers and the shift register are cleared.
- Reset asserted mid-transfer discards in-flight reads; no rd_valid is issued for them.

## Timing

- Request seen high at edge N → ack and RAM signals high in cycle N..N+1 → RAM samples at edge N+1.
- rd_valid rises RD_LATENCY+1 cycles after rd_ack: 3 cycles for the default RD_LATENCY=2.
- Single requester holding req continuously: granted every second cycle.
- Both requesters continuously eligible: strict alternation, one access per cycle total.
- Reader may pipeline requests; rd_valid pulses return in request order.

## Test plan

- Reset: hold tb_rst 200 ns → every output equals its reset value; empty=1, level=0.
- Write 0x1000..0x1003, then read 4 → rd_data_out 0x1000..0x1003 in order; each rd_valid 3 cycles after its rd_ack; level goes 4→0; ram_addr 0..3 for both passes.
- Preload 5 samples, then hold wr_req and rd_req high → grants alternate RD, WR, RD…; the first grant is RD because last_grant=WR; level oscillates between 4 and 5; ram_wr_en never high in an rd_ack cycle.
- Write 1024 samples (0xFFFF down to 0xFC00) → full=1, level=1024. A 1025th wr_req gets no wr_ack and sets overflow=1. One read returns 0xFFFF, and the held write is acked the next eligible cycle at ram_addr=0.
- Wrap: after 1024 writes and 1024 reads, write 0xBEEF → ram_addr=0. A read then returns 0xBEEF with level 1→0.
- rd_req while empty → no rd_ack, underflow=1. Pulse clr with level=7 and one read in flight → level=0, empty=1, underflow=0, next write at ram_addr=0, and the in-flight rd_valid still fires.

Source files
------------

// File: rtl/audio_ram_ring_ctrl.sv
// audio_ram_ring_ctrl: round-robin arbiter and ring-buffer bookkeeping that shares
// one single-port sample RAM between the capture writer and the playback reader.
module audio_ram_ring_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  clr,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  rd_req,
  output logic                  rd_ack,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data_out,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr_en,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0]   LEVEL_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LEVEL_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {GRANT_WR = 1'b0, GRANT_RD = 1'b1} grant_e;

  grant_e                last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d;
  logic                  ram_wr_en_q, ram_wr_en_d, rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] ram_wr_data_q, ram_wr_data_d, rd_data_q, rd_data_d;
  logic [RD_LATENCY:0]   tag_q, tag_d;
  logic                  wr_elig, rd_elig, grant_wr, grant_rd;

  // A request is not eligible in its own ack cycle, so a held request cannot be granted twice.
  always_comb begin
    wr_elig  = wr_req & ~wr_ack_q & ~full_q;
    rd_elig  = rd_req & ~rd_ack_q & ~empty_q;
    grant_rd = ~clr & rd_elig & (~wr_elig | (last_grant_q == GRANT_WR));
    grant_wr = ~clr & wr_elig & ~grant_rd;
  end

  always_comb begin
    last_grant_d  = last_grant_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    level_d       = level_q;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;
    ram_addr_d    = ram_addr_q;
    ram_wr_data_d = ram_wr_data_q;
    wr_ack_d      = grant_wr;
    rd_ack_d      = grant_rd;
    ram_wr_en_d   = grant_wr;
    // Tags keep draining through clr so reads already issued still return data.
    tag_d         = {tag_q[RD_LATENCY-1:0], grant_rd};
    rd_valid_d    = tag_q[RD_LATENCY];
    rd_data_d     = tag_q[RD_LATENCY] ? ram_rd_data : rd_data_q;

    if (clr) begin
      last_grant_d = GRANT_WR;
      wptr_d       = '0;
      rptr_d       = '0;
      level_d      = '0;
      overflow_d   = 1'b0;
      underflow_d  = 1'b0;
    end else begin
      overflow_d  = overflow_q  | (wr_req & ~wr_ack_q & full_q);
      underflow_d = underflow_q | (rd_req & ~rd_ack_q & empty_q);
      if (grant_wr) begin
        ram_addr_d    = wptr_q;
        ram_wr_data_d = wr_data;
        wptr_d        = wptr_q + PTR_ONE;
        level_d       = level_q + LEVEL_ONE;
        last_grant_d  = GRANT_WR;
      end else if (grant_rd) begin
        ram_addr_d   = rptr_q;
        rptr_d       = rptr_q + PTR_ONE;
        level_d      = level_q - LEVEL_ONE;
        last_grant_d = GRANT_RD;
      end
    end

    full_d  = (level_d == LEVEL_FULL);
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      last_grant_q  <= GRANT_WR;
      wptr_q        <= '0;
      rptr_q        <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      ram_addr_q    <= '0;
      ram_wr_data_q <= '0;
      ram_wr_en_q   <= 1'b0;
      wr_ack_q      <= 1'b0;
      rd_ack_q      <= 1'b0;
      tag_q         <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      level_q       <= level_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      ram_addr_q    <= ram_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
      ram_wr_en_q   <= ram_wr_en_d;
      wr_ack_q      <= wr_ack_d;
      rd_ack_q      <= rd_ack_d;
      tag_q         <= tag_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign wr_ack      = wr_ack_q;
  assign rd_ack      = rd_ack_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data_out = rd_data_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wr_en   = ram_wr_en_q;
  assign ram_wr_data = ram_wr_data_q;
  assign level       = level_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_audio_ram_ring_ctrl.sv
// tb_audio_ram_ring_ctrl: directed and random traffic against a queue-based model
// of the ring buffer, with a two-clock registered-output RAM attached to the DUT.
module tb_audio_ram_ring_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0, tb_rst = 1'b1, clr = 1'b0;
  logic          wr_req = 1'b0, rd_req = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack, rd_ack, rd_valid, ram_wr_en, full, empty, overflow, underflow;
  logic [DW-1:0] rd_data_out, ram_wr_data, ram_rd_data, ram_stage;
  logic [AW-1:0] ram_addr;
  logic [AW:0]   level;

  int nCompared = 0;
  int nMismatch = 0;

  audio_ram_ring_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) dut (
    .clk(clk), .tb_rst(tb_rst), .clr(clr),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data_out(rd_data_out),
    .ram_addr(ram_addr), .ram_wr_en(ram_wr_en), .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data),
    .level(level), .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Single-port RAM: address captured at the edge, data out after an output register.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
    ram_stage   <= mem[ram_addr];
    ram_rd_data <= ram_stage;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: contents as a queue, reads carry their sample to a due cycle.
  typedef struct { int due; logic [DW-1:0] data; } pend_t;
  pend_t         pend[$];
  logic [DW-1:0] fifo[$];
  int            cyc = 0, wcnt = 0, rcnt = 0;
  bit            mLastRd = 0, mWrAck = 0, mRdAck = 0, mWen = 0, mRdv = 0, mOvf = 0, mUnf = 0;
  logic [AW-1:0] mAddr = '0;
  logic [DW-1:0] mWdata = '0, mRdata = '0;

  initial begin : model
    bit isFull, isEmpty, we, re, doRd, doWr;
    forever begin
      @(posedge clk or posedge tb_rst);
      if (tb_rst) begin
        pend.delete(); fifo.delete();
        wcnt = 0; rcnt = 0; mLastRd = 0; mWrAck = 0; mRdAck = 0; mWen = 0;
        mRdv = 0; mOvf = 0; mUnf = 0; mAddr = '0; mWdata = '0; mRdata = '0;
      end else begin
        cyc++;
        mRdv = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
          mRdv = 1; mRdata = pend[0].data; void'(pend.pop_front());
        end
        isFull  = (fifo.size() == DEPTH);
        isEmpty = (fifo.size() == 0);
        we = wr_req && !mWrAck && !isFull;
        re = rd_req && !mRdAck && !isEmpty;
        mWrAck = 0; mRdAck = 0; mWen = 0;
        if (clr) begin
          fifo.delete(); wcnt = 0; rcnt = 0; mOvf = 0; mUnf = 0; mLastRd = 0;
        end else begin
          if (wr_req && !mWrAck && isFull) mOvf = 1;
          if (rd_req && !mRdAck && isEmpty) mUnf = 1;
          doRd = (we && re) ? !mLastRd : re;
          doWr = we && !doRd;
          if (doWr) begin
            mWrAck = 1; mWen = 1; mAddr = AW'(wcnt); mWdata = wr_data;
            fifo.push_back(wr_data); wcnt = (wcnt + 1) % DEPTH; mLastRd = 0;
          end else if (doRd) begin
            mRdAck = 1; mAddr = AW'(rcnt);
            pend.push_back('{due: cyc + 3, data: fifo.pop_front()});
            rcnt = (rcnt + 1) % DEPTH; mLastRd = 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, plus event logs for directed checks.
  int            tbCyc = 0;
  int            ackCyc[$], valCyc[$];
  logic [DW-1:0] rdLog[$];
  initial begin : compare
    forever begin
      @(posedge clk); #1;
      tbCyc++;
      if (rd_ack) ackCyc.push_back(tbCyc);
      if (rd_valid) begin valCyc.push_back(tbCyc); rdLog.push_back(rd_data_out); end
      checkOutput("cmp_wr_ack", wr_ack, mWrAck);
      checkOutput("cmp_rd_ack", rd_ack, mRdAck);
      checkOutput("cmp_ram_wr_en", ram_wr_en, mWen);
      checkOutput("cmp_ram_addr", ram_addr, mAddr);
      checkOutput("cmp_ram_wr_data", ram_wr_data, mWdata);
      checkOutput("cmp_rd_valid", rd_valid, mRdv);
      checkOutput("cmp_rd_data_out", rd_data_out, mRdata);
      checkOutput("cmp_level", level, fifo.size());
      checkOutput("cmp_full", full, fifo.size() == DEPTH);
      checkOutput("cmp_empty", empty, fifo.size() == 0);
      checkOutput("cmp_overflow", overflow, mOvf);
      checkOutput("cmp_underflow", underflow, mUnf);
    end
  end

  logic [AW-1:0] addrLog [8];
  logic [AW-1:0] raddrLog [8];

  task automatic waitAck(input bit isRd, output logic [AW-1:0] addr);
    bit ok = 0;
    addr = '0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (isRd ? rd_ack : wr_ack) begin ok = 1; addr = ram_addr; break; end
    end
    if (!ok) checkOutput(isRd ? "rd_ack_timeout" : "wr_ack_timeout", 0, 1);
  endtask

  task automatic writeSamples(input int n, input logic [DW-1:0] start, input int step);
    logic [AW-1:0] a;
    @(negedge clk);
    wr_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      wr_data = start + DW'(i * step);
      waitAck(1'b0, a);
      if (i < 8) addrLog[i] = a;
      @(negedge clk);
    end
    wr_req = 1'b0;
  endtask

  task automatic readSamples(input int n);
    logic [AW-1:0] a;
    @(negedge clk);
    rd_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      waitAck(1'b1, a);
      if (i < 8) raddrLog[i] = a;
      @(negedge clk);
    end
    rd_req = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic waitValid(input string name, input logic [DW-1:0] expData);
    bit ok = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rd_valid) begin ok = 1; break; end
    end
    checkOutput({name, "_seen"}, ok, 1);
    checkOutput({name, "_data"}, rd_data_out, expData);
  endtask

  task automatic pulseClr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic applyStimulus(input int cycles, input int wrPct, input int rdPct);
    fork
      for (int c = 0; c < cycles; c++) begin
        @(negedge clk);
        if (wr_req && wr_ack) wr_req = 1'b0;
        if (!wr_req && $urandom_range(99) < wrPct) begin wr_req = 1'b1; wr_data = DW'($urandom); end
      end
      for (int c = 0; c < cycles; c++) begin
        @(negedge clk);
        if (rd_req && rd_ack) rd_req = 1'b0;
        if (!rd_req && $urandom_range(99) < rdPct) rd_req = 1'b1;
      end
      for (int c = 0; c < cycles; c++) begin
        @(negedge clk);
        clr = ($urandom_range(499) == 0);
      end
    join
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0; clr = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [AW-1:0] a;
    int g [10];

    // Reset state.
    #190;
    checkOutput("rst_level", level, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_acks", {wr_ack, rd_ack, rd_valid, ram_wr_en}, 0);
    checkOutput("rst_rd_data_out", rd_data_out, 0);
    checkOutput("rst_ram_addr", ram_addr, 0);
    checkOutput("rst_ram_wr_data", ram_wr_data, 0);
    checkOutput("rst_flags", {overflow, underflow}, 0);
    @(negedge clk);
    tb_rst = 1'b0;

    // Four writes then four reads in order.
    ackCyc.delete(); valCyc.delete(); rdLog.delete();
    writeSamples(4, 16'h1000, 1);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("t1_waddr%0d", i), addrLog[i], i);
    checkOutput("t1_level4", level, 4);
    readSamples(4);
    checkOutput("t1_nvalid", rdLog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t1_raddr%0d", i), raddrLog[i], i);
      checkOutput($sformatf("t1_data%0d", i), (i < rdLog.size()) ? rdLog[i] : 16'hDEAD, 16'h1000 + i);
      checkOutput($sformatf("t1_lat%0d", i),
                  (i < valCyc.size() && i < ackCyc.size()) ? valCyc[i] - ackCyc[i] : -1, 3);
    end
    checkOutput("t1_level0", level, 0);

    // Both requesters held: strict alternation starting with a read.
    pulseClr();
    writeSamples(5, 16'h5000, 1);
    @(negedge clk);
    wr_data = 16'h5100; wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      g[i] = {rd_ack, wr_ack};
      checkOutput("alt_wen_in_rd", ram_wr_en & rd_ack, 0);
      checkOutput("alt_level", (level == 4) || (level == 5), 1);
      @(negedge clk);
      if (wr_ack) wr_data = wr_data + 16'd1;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    checkOutput("alt_first_rd", g[0], 2);
    for (int i = 1; i < 10; i++) checkOutput($sformatf("alt_seq%0d", i), (g[i] != g[i-1]) && (g[i] != 0) && (g[i] != 3), 1);
    repeat (6) @(posedge clk);

    // Fill to 1024, stall the 1025th write, free one slot.
    pulseClr();
    writeSamples(1024, 16'hFFFF, -1);
    checkOutput("full_flag", full, 1);
    checkOutput("full_level", level, 1024);
    @(negedge clk);
    wr_req = 1'b1; wr_data = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("full_no_ack", wr_ack, 0);
    end
    checkOutput("full_overflow", overflow, 1);
    @(negedge clk); rd_req = 1'b1;
    @(posedge clk); #1;
    checkOutput("full_rd_ack", rd_ack, 1);
    @(negedge clk); rd_req = 1'b0;
    @(posedge clk); #1;
    checkOutput("full_held_ack", wr_ack, 1);
    checkOutput("full_held_addr", ram_addr, 0);
    checkOutput("full_held_data", ram_wr_data, 16'h1234);
    @(negedge clk); wr_req = 1'b0;
    waitValid("full_read", 16'hFFFF);

    // Pointer wrap back to address 0.
    pulseClr();
    writeSamples(1024, 16'h0000, 1);
    readSamples(1024);
    writeSamples(1, 16'hBEEF, 1);
    checkOutput("wrap_waddr", addrLog[0], 0);
    checkOutput("wrap_level1", level, 1);
    rdLog.delete();
    readSamples(1);
    checkOutput("wrap_raddr", raddrLog[0], 0);
    checkOutput("wrap_data", (rdLog.size() > 0) ? rdLog[0] : 16'hDEAD, 16'hBEEF);
    checkOutput("wrap_level0", level, 0);

    // Underflow, then clr with a read still in flight.
    @(negedge clk); rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("unf_no_ack", rd_ack, 0);
    end
    checkOutput("unf_flag", underflow, 1);
    @(negedge clk); rd_req = 1'b0;
    writeSamples(8, 16'h2000, 1);
    @(negedge clk); rd_req = 1'b1;
    waitAck(1'b1, a);
    checkOutput("clr_level7", level, 7);
    @(negedge clk); rd_req = 1'b0; clr = 1'b1;
    @(posedge clk); #1;
    checkOutput("clr_level", level, 0);
    checkOutput("clr_empty", empty, 1);
    checkOutput("clr_underflow", underflow, 0);
    @(negedge clk); clr = 1'b0;
    waitValid("clr_inflight", 16'h2000);
    writeSamples(1, 16'h3000, 1);
    checkOutput("clr_waddr", addrLog[0], 0);

    // Reset in the middle of a read discards it.
    writeSamples(2, 16'h4000, 1);
    @(negedge clk); rd_req = 1'b1;
    waitAck(1'b1, a);
    #1; tb_rst = 1'b1; rd_req = 1'b0;
    repeat (2) @(negedge clk);
    tb_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checkOutput("rst_mid_no_valid", rd_valid, 0);
    end
    checkOutput("rst_mid_level", level, 0);

    // Random traffic, writer-heavy then reader-heavy.
    applyStimulus(3000, 80, 40);
    applyStimulus(2000, 30, 80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
